// File: rtl/bwt_occ_req_arbiter_pkg.sv
// Shared constants for the BWT occurrence-memory request arbiter.
// Source encodings and default widths are aligned with the SMEM READ_NUM_WIDTH.
package bwt_occ_req_arbiter_pkg;

  localparam logic SRC_FWD = 1'b0;
  localparam logic SRC_BCK = 1'b1;

  localparam int READ_NUM_WIDTH = 6;
  localparam int BWT_RN_W       = READ_NUM_WIDTH;
  localparam int BWT_ADDR_W     = 42;

  localparam int ARB_DEPTH   = 4;
  localparam int ARB_SKID    = 2;
  localparam int ARB_MAX_OUT = 8;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/arb_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push on a full FIFO is ignored even
// when a pop happens on the same edge (full is judged before the pop).
module arb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bwt_occ_req_arbiter.sv
// Round-robin arbiter sharing the BWT occ-memory request channel between the
// forward and backward SMEM datapaths. Define BWT_ARB_PERF_EN for perf counters.
module bwt_occ_req_arbiter
  import bwt_occ_req_arbiter_pkg::*;
#(
  parameter int DEPTH   = ARB_DEPTH,
  parameter int SKID    = ARB_SKID,
  parameter int MAX_OUT = ARB_MAX_OUT,
  parameter int ADDR_W  = BWT_ADDR_W,
  parameter int RN_W    = BWT_RN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fwd_req_valid,
  input  logic [RN_W-1:0]   fwd_read_num,
  input  logic [ADDR_W-1:0] fwd_addr_k,
  input  logic [ADDR_W-1:0] fwd_addr_l,
  input  logic              bck_req_valid,
  input  logic [RN_W-1:0]   bck_read_num,
  input  logic [ADDR_W-1:0] bck_addr_k,
  input  logic [ADDR_W-1:0] bck_addr_l,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr_k,
  output logic [ADDR_W-1:0] mem_req_addr_l,
  input  logic              mem_rsp_valid,
  output logic              rsp_src,
  output logic [RN_W-1:0]   rsp_read_num,
  output logic              stall,
  output logic              overflow_err
`ifdef BWT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_fwd_grants,
  output logic [31:0]       perf_bck_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int DW = RN_W + 2 * ADDR_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int TW = RN_W + 1;

  logic          fwd_push, fwd_pop, fwd_full, fwd_empty;
  logic [CW-1:0] fwd_cnt;
  logic [DW-1:0] fwd_head;
  logic          bck_push, bck_pop, bck_full, bck_empty;
  logic [CW-1:0] bck_cnt;
  logic [DW-1:0] bck_head;
  logic          tag_push, tag_pop, tag_full, tag_empty;
  logic [OW-1:0] tag_cnt;
  logic [TW-1:0] tag_head;
  logic [TW-1:0] tag_data;

  logic          sel_src;
  logic [DW-1:0] sel_head;
  logic          handshake;
  logic          tag_cnt_unused;

  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          lock_q, lock_d;
  logic          lock_src_q, lock_src_d;
  logic          rr_q, rr_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;

  assign fwd_push = fwd_req_valid && !fwd_full;
  assign bck_push = bck_req_valid && !bck_full;

  arb_sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_fwd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fwd_push),
    .push_data_i ({fwd_read_num, fwd_addr_k, fwd_addr_l}),
    .pop_i       (fwd_pop),
    .full_o      (fwd_full),
    .empty_o     (fwd_empty),
    .count_o     (fwd_cnt),
    .head_o      (fwd_head)
  );

  arb_sync_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_bck_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bck_push),
    .push_data_i ({bck_read_num, bck_addr_k, bck_addr_l}),
    .pop_i       (bck_pop),
    .full_o      (bck_full),
    .empty_o     (bck_empty),
    .count_o     (bck_cnt),
    .head_o      (bck_head)
  );

  // Tag FIFO records {src, read_num} per issued request; memory answers in order.
  arb_sync_fifo #(.WIDTH(TW), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tag_push),
    .push_data_i (tag_data),
    .pop_i       (tag_pop),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (tag_cnt),
    .head_o      (tag_head)
  );

  // Occupancy is tracked by out_cnt_q; the tag FIFO count is redundant here.
  assign tag_cnt_unused = ^tag_cnt;

  always_comb begin
    sel_src = rr_q;
    if (lock_q) begin
      sel_src = lock_src_q;
    end else if (!fwd_empty && !bck_empty) begin
      sel_src = rr_q;
    end else if (!fwd_empty) begin
      sel_src = SRC_FWD;
    end else begin
      sel_src = SRC_BCK;
    end
  end

  assign sel_head       = (sel_src == SRC_BCK) ? bck_head : fwd_head;
  assign mem_req_valid  = (!fwd_empty || !bck_empty) && (out_cnt_q < OW'(MAX_OUT));
  assign mem_req_addr_k = sel_head[2*ADDR_W-1:ADDR_W];
  assign mem_req_addr_l = sel_head[ADDR_W-1:0];
  assign handshake      = mem_req_valid && mem_req_ready;

  assign fwd_pop  = handshake && (sel_src == SRC_FWD);
  assign bck_pop  = handshake && (sel_src == SRC_BCK);
  assign tag_push = handshake;
  assign tag_data = {sel_src, sel_head[DW-1:2*ADDR_W]};
  assign tag_pop  = mem_rsp_valid && !tag_empty;

  assign rsp_src      = tag_pop ? tag_head[TW-1] : 1'b0;
  assign rsp_read_num = tag_pop ? tag_head[RN_W-1:0] : '0;
  assign stall        = stall_q;
  assign overflow_err = ovf_q;

  always_comb begin
    out_cnt_d  = out_cnt_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    rr_d       = rr_q;
    stall_d    = 1'b0;
    ovf_d      = ovf_q;

    case ({handshake, tag_pop})
      2'b10:   out_cnt_d = out_cnt_q + OW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // A presented-but-refused request freezes source and data until accepted.
    if (handshake) begin
      lock_d = 1'b0;
      rr_d   = other_src(sel_src);
    end else if (mem_req_valid) begin
      lock_d     = 1'b1;
      lock_src_d = sel_src;
    end

    stall_d = (fwd_cnt >= CW'(DEPTH - SKID)) ||
              (bck_cnt >= CW'(DEPTH - SKID)) ||
              (out_cnt_q >= OW'(MAX_OUT - 1));

    if ((fwd_req_valid && fwd_full) || (bck_req_valid && bck_full) ||
        (mem_rsp_valid && tag_empty) || (tag_push && tag_full)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cnt_q  <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_FWD;
      rr_q       <= SRC_FWD;
      stall_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
      stall_q    <= stall_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef BWT_ARB_PERF_EN
  logic [31:0] perf_fwd_q, perf_fwd_d;
  logic [31:0] perf_bck_q, perf_bck_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fwd_d   = perf_fwd_q;
    perf_bck_d   = perf_bck_q;
    perf_stall_d = perf_stall_q;
    if (fwd_pop) perf_fwd_d   = perf_fwd_q + 32'd1;
    if (bck_pop) perf_bck_d   = perf_bck_q + 32'd1;
    if (stall_q) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fwd_q   <= '0;
      perf_bck_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fwd_q   <= perf_fwd_d;
      perf_bck_q   <= perf_bck_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fwd_grants   = perf_fwd_q;
  assign perf_bck_grants   = perf_bck_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_bwt_occ_req_arbiter.sv
// Bench for bwt_occ_req_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the arbiter.
module tb_bwt_occ_req_arbiter;
  import bwt_occ_req_arbiter_pkg::*;

  localparam int DEPTH   = 4;
  localparam int SKID    = 2;
  localparam int MAX_OUT = 8;
  localparam int ADDR_W  = 42;
  localparam int RN_W    = 6;

  logic              clk;
  logic              rst;
  logic              fwd_req_valid;
  logic [RN_W-1:0]   fwd_read_num;
  logic [ADDR_W-1:0] fwd_addr_k, fwd_addr_l;
  logic              bck_req_valid;
  logic [RN_W-1:0]   bck_read_num;
  logic [ADDR_W-1:0] bck_addr_k, bck_addr_l;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr_k, mem_req_addr_l;
  logic              mem_rsp_valid;
  logic              rsp_src;
  logic [RN_W-1:0]   rsp_read_num;
  logic              stall;
  logic              overflow_err;
`ifdef BWT_ARB_PERF_EN
  logic [31:0]       perf_fwd_grants, perf_bck_grants, perf_stall_cycles;
`endif

  bwt_occ_req_arbiter #(
    .DEPTH(DEPTH), .SKID(SKID), .MAX_OUT(MAX_OUT), .ADDR_W(ADDR_W), .RN_W(RN_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fwd_req_valid  (fwd_req_valid),
    .fwd_read_num   (fwd_read_num),
    .fwd_addr_k     (fwd_addr_k),
    .fwd_addr_l     (fwd_addr_l),
    .bck_req_valid  (bck_req_valid),
    .bck_read_num   (bck_read_num),
    .bck_addr_k     (bck_addr_k),
    .bck_addr_l     (bck_addr_l),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr_k (mem_req_addr_k),
    .mem_req_addr_l (mem_req_addr_l),
    .mem_rsp_valid  (mem_rsp_valid),
    .rsp_src        (rsp_src),
    .rsp_read_num   (rsp_read_num),
    .stall          (stall),
    .overflow_err   (overflow_err)
`ifdef BWT_ARB_PERF_EN
    ,
    .perf_fwd_grants   (perf_fwd_grants),
    .perf_bck_grants   (perf_bck_grants),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  typedef struct {
    logic [RN_W-1:0]   rn;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] l;
  } req_t;

  req_t          fq[$];
  req_t          bq[$];
  logic [RN_W:0] exp_q[$];
  int            out_n;
  logic          rr_m, lock_m, lock_src_m, stall_m, ovf_m;
  int            fwd_grants_m, bck_grants_m, stall_cycles_m;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    bq.delete();
    exp_q.delete();
    out_n          = 0;
    rr_m           = SRC_FWD;
    lock_m         = 1'b0;
    lock_src_m     = SRC_FWD;
    stall_m        = 1'b0;
    ovf_m          = 1'b0;
    fwd_grants_m   = 0;
    bck_grants_m   = 0;
    stall_cycles_m = 0;
  endtask

  task automatic idle_inputs();
    fwd_req_valid = 1'b0;
    bck_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic drive_fwd(input logic v);
    fwd_req_valid = v;
    fwd_read_num  = RN_W'($urandom());
    fwd_addr_k    = ADDR_W'({$urandom(), $urandom()});
    fwd_addr_l    = ADDR_W'({$urandom(), $urandom()});
  endtask

  task automatic drive_bck(input logic v);
    bck_req_valid = v;
    bck_read_num  = RN_W'($urandom());
    bck_addr_k    = ADDR_W'({$urandom(), $urandom()});
    bck_addr_l    = ADDR_W'({$urandom(), $urandom()});
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic step();
    int            nf, nb, nt;
    logic          sel, e_valid, hs, stall_next;
    req_t          h;
    nf = fq.size();
    nb = bq.size();
    nt = exp_q.size();
    #1;
    if (lock_m)              sel = lock_src_m;
    else if (nf > 0 && nb > 0) sel = rr_m;
    else if (nf > 0)         sel = SRC_FWD;
    else                     sel = SRC_BCK;
    e_valid = (nf > 0 || nb > 0) && (out_n < MAX_OUT);
    check("mem_req_valid", mem_req_valid, e_valid);
    if (e_valid) begin
      h = (sel == SRC_BCK) ? bq[0] : fq[0];
      check("mem_req_addr_k", mem_req_addr_k, h.k);
      check("mem_req_addr_l", mem_req_addr_l, h.l);
    end
    check("stall", stall, stall_m);
    check("overflow_err", overflow_err, ovf_m);
    if (mem_rsp_valid) begin
      if (nt > 0) begin
        check("rsp_src", rsp_src, exp_q[0][RN_W]);
        check("rsp_read_num", rsp_read_num, exp_q[0][RN_W-1:0]);
      end else begin
        check("rsp_src_notag", rsp_src, 0);
        check("rsp_read_num_notag", rsp_read_num, 0);
      end
    end

    @(posedge clk);
    hs         = e_valid && mem_req_ready;
    stall_next = (nf >= DEPTH - SKID) || (nb >= DEPTH - SKID) || (out_n >= MAX_OUT - 1);
    if (stall_m) stall_cycles_m++;
    if (mem_rsp_valid) begin
      if (nt > 0) begin
        void'(exp_q.pop_front());
        out_n--;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (hs) begin
      if (sel == SRC_FWD) begin
        exp_q.push_back({SRC_FWD, fq[0].rn});
        void'(fq.pop_front());
        fwd_grants_m++;
      end else begin
        exp_q.push_back({SRC_BCK, bq[0].rn});
        void'(bq.pop_front());
        bck_grants_m++;
      end
      out_n++;
      lock_m = 1'b0;
      rr_m   = ~sel;
    end else if (e_valid) begin
      lock_m     = 1'b1;
      lock_src_m = sel;
    end
    if (fwd_req_valid) begin
      if (nf >= DEPTH) ovf_m = 1'b1;
      else fq.push_back('{rn: fwd_read_num, k: fwd_addr_k, l: fwd_addr_l});
    end
    if (bck_req_valid) begin
      if (nb >= DEPTH) ovf_m = 1'b1;
      else bq.push_back('{rn: bck_read_num, k: bck_addr_k, l: bck_addr_l});
    end
    stall_m = stall_next;
    @(negedge clk);
  endtask

  initial begin
    int gi;
    rst = 1'b0;
    idle_inputs();
    drive_fwd(1'b0);
    drive_bck(1'b0);
    model_reset();
    @(negedge clk);
    do_reset();

    // reset state
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_rsp_src", rsp_src, 0);
    check("rst_rsp_read_num", rsp_read_num, 0);
    step();

    // single forward request and its response
    fwd_req_valid = 1'b1; fwd_read_num = 6'd3;
    fwd_addr_k = 42'h10; fwd_addr_l = 42'h20;
    mem_req_ready = 1'b1;
    step();
    fwd_req_valid = 1'b0;
    #1;
    check("t1_valid", mem_req_valid, 1);
    check("t1_k", mem_req_addr_k, 42'h10);
    check("t1_l", mem_req_addr_l, 42'h20);
    step();
    mem_rsp_valid = 1'b1;
    #1;
    check("t1_rsp_src", rsp_src, 0);
    check("t1_rsp_rn", rsp_read_num, 3);
    step();
    mem_rsp_valid = 1'b0;

    // both sources streaming: grants must alternate F,B,F,B
    do_reset();
    gi = 0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fwd_req_valid = (i < 8) && !stall;
      fwd_read_num = RN_W'(i); fwd_addr_k = 42'h100 + ADDR_W'(i); fwd_addr_l = 42'h1000 + ADDR_W'(i);
      bck_req_valid = (i < 8) && !stall;
      bck_read_num = RN_W'(i + 32); bck_addr_k = 42'h200 + ADDR_W'(i); bck_addr_l = 42'h2000 + ADDR_W'(i);
      mem_rsp_valid = (i >= 3) && (exp_q.size() > 0);
      #1;
      if (mem_req_valid) begin
        check("t2_alternate", mem_req_addr_k[11:8], (gi % 2 == 0) ? 4'h1 : 4'h2);
        gi++;
      end
      step();
    end
    idle_inputs();
    check("t2_grants", gi, 2 * (fwd_grants_m > 0 ? fwd_grants_m : 1));

    // backpressure keeps the locked request stable, then other source follows
    do_reset();
    fwd_req_valid = 1'b1; fwd_read_num = 6'd5; fwd_addr_k = 42'h300; fwd_addr_l = 42'h301;
    bck_req_valid = 1'b1; bck_read_num = 6'd6; bck_addr_k = 42'h400; bck_addr_l = 42'h401;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_k", mem_req_addr_k, 42'h300);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    #1;
    check("t3_next_k", mem_req_addr_k, 42'h400);
    step();
    idle_inputs();

    // outstanding limit
    do_reset();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_bck(1'b1);
      step();
    end
    drive_bck(1'b0);
    for (int i = 0; i < 3; i++) step();
    #1;
    check("t4_blocked", mem_req_valid, 0);
    check("t4_stall", stall, 1);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("t4_resume", mem_req_valid, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      mem_rsp_valid = exp_q.size() > 0;
      step();
    end
    idle_inputs();

    // FIFO fill with ready low: stall then overflow, overflow sticky
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_fwd(1'b1);
      step();
    end
    drive_fwd(1'b0);
    #1;
    check("t5_stall", stall, 1);
    check("t5_overflow", overflow_err, 1);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #1;
    check("t5_sticky", overflow_err, 1);
    idle_inputs();

    // reset with requests in flight; a late response is an error
    do_reset();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_fwd(i < 3);
      step();
    end
    check("t6_inflight", out_n, 3);
    do_reset();
    #1;
    check("t6_valid_cleared", mem_req_valid, 0);
    check("t6_ovf_cleared", overflow_err, 0);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check("t6_late_rsp", overflow_err, 1);
    step();

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      drive_fwd(($urandom_range(0, 99) < 55) && (!stall || $urandom_range(0, 19) == 0));
      drive_bck(($urandom_range(0, 99) < 55) && (!stall || $urandom_range(0, 19) == 0));
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      step();
    end
    idle_inputs();
    step();

`ifdef BWT_ARB_PERF_EN
    #1;
    check("perf_fwd", perf_fwd_grants, fwd_grants_m);
    check("perf_bck", perf_bck_grants, bck_grants_m);
    check("perf_stall", perf_stall_cycles, stall_cycles_m);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
